store_write_buffer: RTL and testbench

Sits directly downstream of the store data formatter and upstream of the data-memory write port.
- Accepts store requests: address, zero-extended store data, funct3.
- Replicates data into the correct byte lanes and generates byte strobes.
- Queues requests in an in-order FIFO and issues them to memory over a valid/ready handshake.
- Misaligned or illegal stores are dropped and reported as a fault instead of being written.

---
 rtl/store_write_buffer.sv | 71 +++++++
 tb/tb_store_write_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: formats stores into byte lanes/strobes, drops misaligned or illegal ones as faults, and queues the rest in order toward memory
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [ADDR_W-1:0]      io_in_addr,
  input  logic [31:0]            io_in_data,
  input  logic [2:0]             io_in_funct3,
  output logic                   io_mem_valid,
  input  logic                   io_mem_ready,
  output logic [ADDR_W-1:0]      io_mem_addr,
  output logic [31:0]            io_mem_wdata,
  output logic [3:0]             io_mem_wstrb,
  output logic [$clog2(DEPTH):0] io_count,
  output logic                   io_empty,
  output logic                   io_fault,
  output logic [ADDR_W-1:0]      io_fault_addr
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0] strb_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [1:0] a;
  logic legal, accept, push, pop;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  always_comb begin
    a = io_in_addr[1:0];
    legal = (io_in_funct3 == 3'd0) || (io_in_funct3 == 3'd1 && !a[0]) || (io_in_funct3 == 3'd2 && a == 2'd0);
    wdata = io_in_funct3 == 3'd0 ? {4{io_in_data[7:0]}} : io_in_funct3 == 3'd1 ? {2{io_in_data[15:0]}} : io_in_data;
    wstrb = io_in_funct3 == 3'd0 ? 4'b0001 << a : io_in_funct3 == 3'd1 ? 4'b0011 << a : 4'b1111;
    io_in_ready = count < (PW+1)'(DEPTH);
    accept = io_in_valid && io_in_ready;
    push = accept && legal;
    io_mem_valid = count != '0;
    pop = io_mem_valid && io_mem_ready;
    io_empty = count == '0;
    io_count = count;
    io_mem_addr = addr_q[rd_ptr];
    io_mem_wdata = data_q[rd_ptr];
    io_mem_wstrb = strb_q[rd_ptr];
  end
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr] <= {io_in_addr[ADDR_W-1:2], 2'b00};
      data_q[wr_ptr] <= wdata;
      strb_q[wr_ptr] <= wstrb;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      io_fault <= 1'b0;
      io_fault_addr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      io_fault <= accept && !legal;
      if (accept && !legal) io_fault_addr <= io_in_addr;
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
  logic clock = 0, reset = 1;
  logic io_in_valid = 0, io_in_ready, io_mem_valid, io_mem_ready = 0, io_empty, io_fault;
  logic [31:0] io_in_addr = 0, io_in_data = 0, io_mem_addr, io_mem_wdata, io_fault_addr;
  logic [2:0] io_in_funct3 = 0, io_count;
  logic [3:0] io_mem_wstrb;
  int checks = 0, failures = 0;
  logic [31:0] q [$];
  int cnt;
  store_write_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_addr(io_in_addr), .io_in_data(io_in_data), .io_in_funct3(io_in_funct3),
    .io_mem_valid(io_mem_valid), .io_mem_ready(io_mem_ready), .io_mem_addr(io_mem_addr),
    .io_mem_wdata(io_mem_wdata), .io_mem_wstrb(io_mem_wstrb), .io_count(io_count),
    .io_empty(io_empty), .io_fault(io_fault), .io_fault_addr(io_fault_addr));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push_one(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    io_in_valid = 1;
    io_in_addr = addr;
    io_in_data = data;
    io_in_funct3 = f3;
    tick();
    io_in_valid = 0;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_count", io_count, 0);
    chk("rst_empty", io_empty, 1);
    chk("rst_mvalid", io_mem_valid, 0);
    chk("rst_fault", io_fault, 0);
    chk("rst_faddr", io_fault_addr, 0);
    chk("rst_ready", io_in_ready, 1);
    io_mem_ready = 1;
    push_one(32'h100, 32'hDEADBEEF, 3'd2);
    chk("sw_valid", io_mem_valid, 1);
    chk("sw_addr", io_mem_addr, 32'h100);
    chk("sw_wdata", io_mem_wdata, 32'hDEADBEEF);
    chk("sw_wstrb", io_mem_wstrb, 4'hF);
    chk("sw_count1", io_count, 1);
    tick();
    chk("sw_count0", io_count, 0);
    chk("sw_empty", io_empty, 1);
    chk("sw_mvalid0", io_mem_valid, 0);
    io_mem_ready = 0;
    push_one(32'h203, 32'h000000A5, 3'd0);
    chk("sb_addr", io_mem_addr, 32'h200);
    chk("sb_wdata", io_mem_wdata, 32'hA5A5A5A5);
    chk("sb_wstrb", io_mem_wstrb, 4'h8);
    io_mem_ready = 1;
    tick();
    io_mem_ready = 0;
    push_one(32'h302, 32'h00001234, 3'd1);
    chk("sh_addr", io_mem_addr, 32'h300);
    chk("sh_wdata", io_mem_wdata, 32'h12341234);
    chk("sh_wstrb", io_mem_wstrb, 4'hC);
    io_mem_ready = 1;
    tick();
    chk("sh_drain", io_count, 0);
    io_mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      io_in_valid = 1;
      io_in_addr = 32'h400 + 32'(4 * i);
      io_in_data = 32'(i + 1);
      io_in_funct3 = 3'd2;
      chk($sformatf("full_ready%0d", i), io_in_ready, i < 4);
      tick();
    end
    io_in_valid = 0;
    chk("full_count", io_count, 4);
    chk("full_ready", io_in_ready, 0);
    chk("full_hold_addr", io_mem_addr, 32'h400);
    chk("full_hold_data", io_mem_wdata, 1);
    io_mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), io_mem_valid, 1);
      chk($sformatf("drain_addr%0d", i), io_mem_addr, 32'h400 + 32'(4 * i));
      chk($sformatf("drain_data%0d", i), io_mem_wdata, 32'(i + 1));
      tick();
    end
    chk("drain_count", io_count, 0);
    chk("drain_empty", io_empty, 1);
    push_one(32'h102, 32'h11111111, 3'd2);
    chk("f1_fault", io_fault, 1);
    chk("f1_faddr", io_fault_addr, 32'h102);
    chk("f1_count", io_count, 0);
    chk("f1_mvalid", io_mem_valid, 0);
    tick();
    chk("f1_pulse", io_fault, 0);
    chk("f1_hold", io_fault_addr, 32'h102);
    push_one(32'h101, 32'h2222, 3'd1);
    chk("f2_fault", io_fault, 1);
    chk("f2_faddr", io_fault_addr, 32'h101);
    chk("f2_count", io_count, 0);
    push_one(32'h500, 32'h3333, 3'd3);
    chk("f3_fault", io_fault, 1);
    chk("f3_faddr", io_fault_addr, 32'h500);
    chk("f3_count", io_count, 0);
    push_one(32'h601, 32'h44, 3'd0);
    chk("sb_odd_nofault", io_fault, 0);
    chk("sb_odd_strb", io_mem_wstrb, 4'h2);
    tick();
    chk("sb_odd_drain", io_count, 0);
    io_mem_ready = 0;
    push_one(32'h700, 32'h70, 3'd2);
    q.push_back(32'h70);
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      io_mem_ready = (i % 2) == 0;
      io_in_valid = 1;
      io_in_addr = 32'h704 + 32'(4 * i);
      io_in_data = 32'h71 + 32'(i);
      io_in_funct3 = 3'd2;
      chk($sformatf("strm_ready%0d", i), io_in_ready, cnt < 4);
      if (io_mem_ready && q.size() > 0) begin
        chk($sformatf("strm_mvalid%0d", i), io_mem_valid, 1);
        chk($sformatf("strm_wdata%0d", i), io_mem_wdata, q.pop_front());
      end
      if (cnt < 4) q.push_back(io_in_data);
      cnt = q.size();
      tick();
      chk($sformatf("strm_count%0d", i), io_count, 3'(cnt));
    end
    io_in_valid = 0;
    io_mem_ready = 0;
    chk("pre_rst_count", io_count, 3);
    chk("pre_rst_head", io_mem_wdata, q[0]);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_count", io_count, 0);
    chk("mid_rst_mvalid", io_mem_valid, 0);
    chk("mid_rst_faddr", io_fault_addr, 0);
    io_mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", i), io_mem_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
